// File: rtl/maze_pkg.sv
// Shared types for the depth-first maze solver: move directions and controller states.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INIT,
        ST_PROBE,
        ST_BACKTRACK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // The encoding is chosen so that undoing a move is its bitwise complement.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/dir_stack.sv
// LIFO of moves taken by the solver, with an independent read port so the
// finished path can be streamed out from the bottom of the stack.
module dir_stack
    import maze_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  dir_t          push_dir,
    output dir_t          top_dir,
    output logic [AW:0]   sp,
    input  logic [AW-1:0] rd_addr,
    output dir_t          rd_dir
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    dir_t          mem [DEPTH];
    logic [AW-1:0] top_idx;

    assign top_idx = sp[AW-1:0] - AW'(1);
    assign top_dir = mem[top_idx];
    assign rd_dir  = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + (AW+1)'(1);
        end else if (pop) begin
            sp <= sp - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp[AW-1:0]] <= push_dir;
        end
    end

    // A simple path never revisits a cell, so the stack can never fill up.
    assert property (@(posedge clk) disable iff (rst) push |-> sp != FULL);

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver: wall bitmap loaded over a config port, search from a
// start cell to a goal cell, then the found path is streamed out with valid/ready.
module maze_dfs_solver
    import maze_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_wr,
    input  logic [ROW_W-1:0]       cfg_row,
    input  logic [COL_W-1:0]       cfg_col,
    input  logic                   cfg_wall,
    input  logic [ROW_W-1:0]       start_row,
    input  logic [COL_W-1:0]       start_col,
    input  logic [ROW_W-1:0]       goal_row,
    input  logic [COL_W-1:0]       goal_col,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ROW_W+COL_W:0]   path_len,
    output logic [31:0]            step_count,
    output logic                   out_valid,
    output logic [1:0]             out_dir,
    output logic                   out_last,
    input  logic                   out_ready
);

    localparam int AW    = ROW_W + COL_W;
    localparam int CELLS = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = '1;

    state_t           state;
    dir_t             dir;
    logic [ROW_W-1:0] cur_row, goal_r, nb_row;
    logic [COL_W-1:0] cur_col, goal_c, nb_col;
    logic [AW-1:0]    clr_idx, cur_idx, nb_idx;
    logic [AW:0]      rp, rp_adv, sp;
    logic [CELLS-1:0] wall_map, visited;
    dir_t             mv_dir, top_dir, rd_dir;
    logic             in_range, nb_open, push, pop, start_ok;

    assign cur_idx  = {cur_row, cur_col};
    assign nb_idx   = {nb_row, nb_col};
    assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
    assign mv_dir   = (state == ST_BACKTRACK) ? opposite(top_dir) : dir;
    assign nb_open  = in_range && !wall_map[nb_idx] && !visited[nb_idx];
    assign push     = (state == ST_PROBE) && nb_open;
    assign pop      = (state == ST_BACKTRACK) && (sp != '0);
    assign rp_adv   = rp + {{AW{1'b0}}, (out_valid && out_ready)};

    // Shared neighbour calculator: probe direction normally, reverse of the popped move when backtracking.
    always_comb begin
        nb_row   = cur_row;
        nb_col   = cur_col;
        in_range = 1'b0;
        unique case (mv_dir)
            DIR_UP: begin
                in_range = (cur_row != '0);
                nb_row   = cur_row - ROW_W'(1);
            end
            DIR_RIGHT: begin
                in_range = (cur_col != '1);
                nb_col   = cur_col + COL_W'(1);
            end
            DIR_LEFT: begin
                in_range = (cur_col != '0);
                nb_col   = cur_col - COL_W'(1);
            end
            DIR_DOWN: begin
                in_range = (cur_row != '1);
                nb_row   = cur_row + ROW_W'(1);
            end
        endcase
    end

    dir_stack #(.AW(AW)) u_stack (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .push     (push),
        .pop      (pop),
        .push_dir (dir),
        .top_dir  (top_dir),
        .sp       (sp),
        .rd_addr  (rp_adv[AW-1:0]),
        .rd_dir   (rd_dir)
    );

    // The wall map survives reset so a host can reload a solve without rewriting the maze.
    always_ff @(posedge clk) begin
        if (cfg_wr && !busy) begin
            wall_map[{cfg_row, cfg_col}] <= cfg_wall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dir        <= DIR_UP;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_dir    <= 2'b00;
            path_len   <= '0;
            step_count <= '0;
            rp         <= '0;
            clr_idx    <= '0;
        end else if (start_ok) begin
            cur_row    <= start_row;
            cur_col    <= start_col;
            goal_r     <= goal_row;
            goal_c     <= goal_col;
            step_count <= '0;
            path_len   <= '0;
            clr_idx    <= '0;
            rp         <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            state      <= ST_CLEAR;
        end else begin
            case (state)
                ST_CLEAR: begin
                    visited[clr_idx] <= 1'b0;
                    clr_idx          <= clr_idx + AW'(1);
                    if (clr_idx == LAST_IDX) begin
                        state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (wall_map[cur_idx]) begin
                        state <= ST_FAIL;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                    end else begin
                        visited[cur_idx] <= 1'b1;
                        if (cur_row == goal_r && cur_col == goal_c) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_PROBE;
                            dir   <= DIR_UP;
                        end
                    end
                end
                ST_PROBE: begin
                    if (nb_open) begin
                        visited[nb_idx] <= 1'b1;
                        cur_row         <= nb_row;
                        cur_col         <= nb_col;
                        step_count      <= step_count + 32'd1;
                        dir             <= DIR_UP;
                        if (nb_row == goal_r && nb_col == goal_c) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            path_len <= sp + (AW+1)'(1);
                        end
                    end else if (dir == DIR_DOWN) begin
                        state <= ST_BACKTRACK;
                    end else begin
                        dir <= dir_t'(dir + 2'd1);
                    end
                end
                ST_BACKTRACK: begin
                    if (sp == '0) begin
                        state    <= ST_FAIL;
                        busy     <= 1'b0;
                        fail     <= 1'b1;
                        path_len <= '0;
                    end else begin
                        cur_row    <= nb_row;
                        cur_col    <= nb_col;
                        step_count <= step_count + 32'd1;
                        dir        <= DIR_UP;
                        state      <= ST_PROBE;
                    end
                end
                // Readout looks one element ahead so out_dir/out_last are registered yet hold under stall.
                ST_DONE: begin
                    rp        <= rp_adv;
                    out_valid <= (rp_adv < sp);
                    out_dir   <= rd_dir;
                    out_last  <= (rp_adv == sp - (AW+1)'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_dfs_solver.sv
// Self-checking bench for maze_dfs_solver on a 4x4 maze: directed scenarios with a path scoreboard.
module tb_maze_dfs_solver;

    localparam int ROW_W = 2;
    localparam int COL_W = 2;
    localparam int CELLS = 1 << (ROW_W + COL_W);
    localparam logic [1:0] R = 2'b01, L = 2'b10, D = 2'b11;
    localparam logic [1:0] OPEN_PATH [12] = '{R, R, R, D, L, L, L, D, R, R, R, D};
    localparam logic [1:0] DEAD_PATH [3]  = '{D, D, D};

    logic                 clk = 1'b0;
    logic                 rst, start, cfg_wr, cfg_wall, out_ready;
    logic [ROW_W-1:0]     cfg_row, start_row, goal_row;
    logic [COL_W-1:0]     cfg_col, start_col, goal_col;
    logic                 busy, done, fail, out_valid, out_last;
    logic [ROW_W+COL_W:0] path_len;
    logic [31:0]          step_count;
    logic [1:0]           out_dir;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic       got_last_q[$];

    maze_dfs_solver #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_wr     (cfg_wr),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_wall   (cfg_wall),
        .start_row  (start_row),
        .start_col  (start_col),
        .goal_row   (goal_row),
        .goal_col   (goal_col),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .path_len   (path_len),
        .step_count (step_count),
        .out_valid  (out_valid),
        .out_dir    (out_dir),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_wall(input int r, input int c, input logic w);
        cfg_wr   = 1'b1;
        cfg_row  = r[ROW_W-1:0];
        cfg_col  = c[COL_W-1:0];
        cfg_wall = w;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic open_maze();
        for (int r = 0; r < (1 << ROW_W); r++)
            for (int c = 0; c < (1 << COL_W); c++)
                write_wall(r, c, 1'b0);
    endtask

    task automatic start_solve(input int sr, input int sc, input int gr, input int gc);
        start_row = sr[ROW_W-1:0];
        start_col = sc[COL_W-1:0];
        goal_row  = gr[ROW_W-1:0];
        goal_col  = gc[COL_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done || fail) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic collect(input int pct, input int cycles);
        got_q.delete();
        got_last_q.delete();
        for (int i = 0; i < cycles; i++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) begin
                got_q.push_back(out_dir);
                got_last_q.push_back(out_last);
            end
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, fail, out_valid, out_last} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000", {busy, done, fail, out_valid, out_last});
        end
        n_checks++;
        if (path_len !== '0 || step_count !== 32'd0 || out_dir !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_counts: got len=%0d steps=%0d dir=%0d, expected 0/0/0", path_len, step_count, out_dir);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_open_maze();
        bit ok;
        open_maze();
        foreach (OPEN_PATH[i]) exp_q.push_back(OPEN_PATH[i]);
        start_solve(0, 0, 3, 3);
        wait_end(ok);
        n_checks++;
        if (!ok || done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL open_status: got ok=%0d done=%b fail=%b busy=%b, expected 1/1/0/0", ok, done, fail, busy);
        end
        n_checks++;
        if (path_len !== 12 || step_count !== 32'd12) begin
            n_fail++;
            $display("[TB] FAIL open_len: got len=%0d steps=%0d, expected 12/12", path_len, step_count);
        end
        collect(100, 40);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL open_count: got %0d elements, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [1:0] g, e;
            logic gl;
            g = got_q.pop_front();
            gl = got_last_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e || gl !== (exp_q.size() == 0)) begin
                n_fail++;
                $display("[TB] FAIL open_elem: got dir=%0d last=%b, expected dir=%0d last=%b", g, gl, e, exp_q.size() == 0);
            end
        end
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL open_drained: got valid=%b done=%b, expected 0/1", out_valid, done);
        end
    endtask

    task automatic test_blocked_goal();
        bit ok;
        open_maze();
        write_wall(2, 3, 1'b1);
        write_wall(3, 2, 1'b1);
        start_solve(0, 0, 3, 3);
        wait_end(ok);
        n_checks++;
        if (!ok || fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || path_len !== '0) begin
            n_fail++;
            $display("[TB] FAIL blocked_status: got ok=%0d fail=%b done=%b busy=%b len=%0d, expected 1/1/0/0/0",
                     ok, fail, done, busy, path_len);
        end
        collect(100, 30);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL blocked_valid: got %0d elements, expected 0", got_q.size());
        end
    endtask

    task automatic test_start_wall();
        int cnt;
        open_maze();
        write_wall(0, 0, 1'b1);
        start_row = '0;
        start_col = '0;
        goal_row  = '1;
        goal_col  = '1;
        start = 1'b1;
        cnt = 0;
        do begin
            tick();
            start = 1'b0;
            cnt++;
        end while (!fail && cnt < 200);
        n_checks++;
        if (cnt != CELLS + 2) begin
            n_fail++;
            $display("[TB] FAIL wall_start_latency: got %0d cycles, expected %0d", cnt, CELLS + 2);
        end
        n_checks++;
        if (path_len !== '0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wall_start_state: got len=%0d valid=%b done=%b, expected 0/0/0", path_len, out_valid, done);
        end
    endtask

    task automatic test_start_is_goal();
        bit ok;
        write_wall(0, 0, 1'b0);
        start_solve(1, 2, 1, 2);
        wait_end(ok);
        n_checks++;
        if (!ok || done !== 1'b1 || path_len !== '0 || step_count !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL same_cell: got ok=%0d done=%b len=%0d steps=%0d, expected 1/1/0/0", ok, done, path_len, step_count);
        end
        collect(100, 20);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL same_cell_valid: got %0d elements, expected 0", got_q.size());
        end
    endtask

    task automatic test_backtrack();
        bit ok;
        open_maze();
        write_wall(1, 1, 1'b1);
        write_wall(1, 2, 1'b1);
        write_wall(1, 3, 1'b1);
        write_wall(2, 1, 1'b1);
        foreach (DEAD_PATH[i]) exp_q.push_back(DEAD_PATH[i]);
        start_solve(0, 0, 3, 0);
        wait_end(ok);
        n_checks++;
        if (!ok || done !== 1'b1 || path_len !== 3 || step_count !== 32'd9) begin
            n_fail++;
            $display("[TB] FAIL backtrack_status: got ok=%0d done=%b len=%0d steps=%0d, expected 1/1/3/9",
                     ok, done, path_len, step_count);
        end
        collect(100, 20);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL backtrack_count: got %0d elements, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [1:0] g, e;
            logic gl;
            g = got_q.pop_front();
            gl = got_last_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e || gl !== (exp_q.size() == 0)) begin
                n_fail++;
                $display("[TB] FAIL backtrack_elem: got dir=%0d last=%b, expected dir=%0d last=%b", g, gl, e, exp_q.size() == 0);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok, stalled;
        logic [1:0] prev_dir;
        logic prev_last;
        open_maze();
        foreach (OPEN_PATH[i]) exp_q.push_back(OPEN_PATH[i]);
        start_solve(0, 0, 3, 3);
        wait_end(ok);
        n_checks++;
        if (!ok || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_status: got ok=%0d done=%b, expected 1/1", ok, done);
        end
        stalled = 1'b0;
        prev_dir = 2'b00;
        prev_last = 1'b0;
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 99) < 30);
            if (stalled) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_dir !== prev_dir || out_last !== prev_last) begin
                    n_fail++;
                    $display("[TB] FAIL bp_stable: got valid=%b dir=%0d last=%b, expected 1/%0d/%b",
                             out_valid, out_dir, out_last, prev_dir, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                logic [1:0] e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL bp_extra: got dir=%0d, expected no element", out_dir);
                end else begin
                    e = exp_q.pop_front();
                    if (out_dir !== e || out_last !== (exp_q.size() == 0)) begin
                        n_fail++;
                        $display("[TB] FAIL bp_elem: got dir=%0d last=%b, expected dir=%0d last=%b",
                                 out_dir, out_last, e, exp_q.size() == 0);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            prev_dir = out_dir;
            prev_last = out_last;
            tick();
        end
        out_ready = 1'b1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_delivered: got %0d undelivered, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_solve();
        bit ok;
        open_maze();
        start_solve(0, 0, 3, 3);
        write_wall(0, 1, 1'b1);
        repeat (CELLS + 4) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_busy: got busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || step_count !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got busy=%b done=%b valid=%b steps=%0d, expected 0/0/0/0",
                     busy, done, out_valid, step_count);
        end
        foreach (OPEN_PATH[i]) exp_q.push_back(OPEN_PATH[i]);
        start_solve(0, 0, 3, 3);
        wait_end(ok);
        n_checks++;
        if (!ok || done !== 1'b1 || path_len !== 12 || step_count !== 32'd12) begin
            n_fail++;
            $display("[TB] FAIL rerun_status: got ok=%0d done=%b len=%0d steps=%0d, expected 1/1/12/12",
                     ok, done, path_len, step_count);
        end
        collect(100, 40);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL rerun_count: got %0d elements, expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [1:0] g, e;
            logic gl;
            g = got_q.pop_front();
            gl = got_last_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e || gl !== (exp_q.size() == 0)) begin
                n_fail++;
                $display("[TB] FAIL rerun_elem: got dir=%0d last=%b, expected dir=%0d last=%b", g, gl, e, exp_q.size() == 0);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_wall  = 1'b0;
        cfg_row   = '0;
        cfg_col   = '0;
        start_row = '0;
        start_col = '0;
        goal_row  = '0;
        goal_col  = '0;
        out_ready = 1'b1;
        test_reset();
        test_open_maze();
        test_blocked_goal();
        test_start_wall();
        test_start_is_goal();
        test_backtrack();
        test_backpressure();
        test_reset_mid_solve();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
